// File: rtl/mem_if_sram_slave_pkg.sv
// Shared mem_if definitions: field widths, request/response layouts, op codes
// and the slave FSM state type.
package mem_if_sram_slave_pkg;

   localparam int RCT_MEM_ADDR_W = 32;
   localparam int RCT_MEM_DATA_W = 32;
   localparam int RCT_MEM_MASK_W = 4;
   localparam int CPUNOC_TID_W   = 16;
   localparam int MEM_OP_W       = 3;
   localparam int MEM_REQ_W      = MEM_OP_W + CPUNOC_TID_W + RCT_MEM_ADDR_W + RCT_MEM_MASK_W + RCT_MEM_DATA_W;
   localparam int MEM_RESP_W     = MEM_OP_W + CPUNOC_TID_W + RCT_MEM_DATA_W;

   // Request field offsets (LSB positions)
   localparam int REQ_OP_LSB    = 84;
   localparam int REQ_TID_LSB   = 68;
   localparam int REQ_ADDR_LSB  = 36;
   localparam int REQ_MASK_LSB  = 32;
   localparam int REQ_WDATA_LSB = 0;

   // Response field offsets (LSB positions)
   localparam int RESP_OP_LSB    = 48;
   localparam int RESP_TID_LSB   = 32;
   localparam int RESP_RDATA_LSB = 0;

   localparam logic [MEM_OP_W-1:0] MEM_OP_RD  = 3'd0;
   localparam logic [MEM_OP_W-1:0] MEM_OP_WR  = 3'd1;
   localparam logic [MEM_OP_W-1:0] MEM_OP_ERR = 3'd7;

   // Field order matches the bit offsets above (op is the MSB group).
   typedef struct packed {
      logic [MEM_OP_W-1:0]       op;
      logic [CPUNOC_TID_W-1:0]   tid;
      logic [RCT_MEM_ADDR_W-1:0] addr;
      logic [RCT_MEM_MASK_W-1:0] mask;
      logic [RCT_MEM_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [MEM_OP_W-1:0]       op;
      logic [CPUNOC_TID_W-1:0]   tid;
      logic [RCT_MEM_DATA_W-1:0] rdata;
   } mem_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } slave_state_t;

   // Only plain reads and writes are serviced; anything else is an error.
   function automatic logic mem_op_known(input logic [MEM_OP_W-1:0] op);
      return (op == MEM_OP_RD) || (op == MEM_OP_WR);
   endfunction

endpackage

// File: rtl/mem_if_sram_slave_array.sv
// Single-port DEPTH x 32 word array built from four byte lanes.
// Synchronous byte-enabled write, combinational read. Contents are never reset.
module mem_if_sram_slave_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : lane_g
         logic [7:0] lane_mem [DEPTH];

         // Byte lane write: only when the write strobe and this lane's enable are set
         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               lane_mem[addr] <= wdata[8*gi +: 8];
            end
         end

         assign rdata[8*gi +: 8] = lane_mem[addr];
      end
   endgenerate

endmodule

// File: rtl/mem_if_sram_slave.sv
// mem_if SRAM slave: accepts one request at a time, commits byte-masked writes
// at accept, and returns a response after LATENCY extra wait cycles.
module mem_if_sram_slave
   import mem_if_sram_slave_pkg::*;
#(
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2,
   parameter logic [31:0] BASE    = 32'h0
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  mem_if_req_valid,
   output logic                  mem_if_req_ready,
   input  logic [MEM_REQ_W-1:0]  mem_if_req,
   output logic                  mem_if_resp_valid,
   input  logic                  mem_if_resp_ready,
   output logic [MEM_RESP_W-1:0] mem_if_resp
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   slave_state_t            state_reg;
   logic                    ready_reg;
   logic                    resp_valid_reg;
   mem_resp_t               resp_reg;
   logic [3:0]              cnt_reg;
   logic [MEM_OP_W-1:0]     op_reg;
   logic [CPUNOC_TID_W-1:0] tid_reg;
   logic [AW-1:0]           idx_reg;

   mem_req_t                req_s;
   logic [31:0]             offset;
   logic                    in_range;
   logic [MEM_OP_W-1:0]     eff_op;
   logic [AW-1:0]           req_idx;
   logic                    accept;
   logic [AW-1:0]           arr_idx;
   logic [31:0]             arr_rdata;

   // Request decode: relative offset with 32-bit wrap, range and op validity
   assign req_s    = mem_req_t'(mem_if_req);
   assign offset   = req_s.addr - BASE;
   assign in_range = ({1'b0, offset} < SPAN);
   assign eff_op   = (in_range && mem_op_known(req_s.op)) ? req_s.op : MEM_OP_ERR;
   assign req_idx  = offset[AW+1:2];
   assign accept   = mem_if_req_valid && ready_reg;

   // The array is only written in IDLE, so one address port serves both paths
   assign arr_idx  = (state_reg == ST_IDLE) ? req_idx : idx_reg;

   mem_if_sram_slave_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk_i),
      .we    (accept && (eff_op == MEM_OP_WR)),
      .be    (req_s.mask),
      .addr  (arr_idx),
      .wdata (req_s.wdata),
      .rdata (arr_rdata)
   );

   assign mem_if_req_ready  = ready_reg;
   assign mem_if_resp_valid = resp_valid_reg;
   assign mem_if_resp       = resp_reg;

   // Transaction FSM with registered handshake outputs and response word
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         state_reg      <= ST_IDLE;
         ready_reg      <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_reg       <= '0;
         cnt_reg        <= 4'd0;
         op_reg         <= MEM_OP_RD;
         tid_reg        <= '0;
         idx_reg        <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ready_reg <= 1'b1;
               if (accept) begin
                  ready_reg <= 1'b0;
                  op_reg    <= eff_op;
                  tid_reg   <= req_s.tid;
                  idx_reg   <= req_idx;
                  if (LATENCY == 0) begin
                     state_reg      <= ST_RESP;
                     resp_valid_reg <= 1'b1;
                     resp_reg.op    <= eff_op;
                     resp_reg.tid   <= req_s.tid;
                     resp_reg.rdata <= (eff_op == MEM_OP_RD) ? arr_rdata : 32'h0;
                  end else begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg      <= ST_RESP;
                  resp_valid_reg <= 1'b1;
                  resp_reg.op    <= op_reg;
                  resp_reg.tid   <= tid_reg;
                  resp_reg.rdata <= (op_reg == MEM_OP_RD) ? arr_rdata : 32'h0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_RESP: begin
               if (mem_if_resp_ready) begin
                  state_reg      <= ST_IDLE;
                  resp_valid_reg <= 1'b0;
                  ready_reg      <= 1'b1;
               end
            end
            default: begin
               state_reg      <= ST_IDLE;
               ready_reg      <= 1'b0;
               resp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_if_sram_slave.sv
// Self-checking bench for mem_if_sram_slave (DEPTH=1024, LATENCY=2, BASE=0).
// Expected values come from a word-array reference model updated per accepted request.
module tb_mem_if_sram_slave;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;
   localparam int TMO     = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [86:0] req = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [50:0] resp;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one 32-bit word per index plus a "written" flag
   logic [31:0] model_mem   [DEPTH];
   bit          model_known [DEPTH];

   // Cycle stamp of every accepted request, used for throughput checks
   int cyc = 0;
   int accept_cyc [$];

   mem_if_sram_slave #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY),
      .BASE    (32'h0)
   ) dut (
      .clk_i             (clk),
      .rstn_i            (rst),
      .mem_if_req_valid  (req_valid),
      .mem_if_req_ready  (req_ready),
      .mem_if_req        (req),
      .mem_if_resp_valid (resp_valid),
      .mem_if_resp_ready (resp_ready),
      .mem_if_resp       (resp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req_valid && req_ready && !rst) accept_cyc.push_back(cyc);
   end

   // ---- reference model ----
   function automatic logic [2:0] exp_op(input logic [2:0] op, input logic [31:0] addr);
      if (addr >= 32'(DEPTH * 4) || op > 3'd1) return 3'd7;
      return op;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = wd[8*k +: 8];
      return r;
   endfunction

   task automatic model_apply(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                              input logic [31:0] wd);
      int idx;
      if (exp_op(op, addr) == 3'd1) begin
         idx = int'(addr / 4);
         model_mem[idx]   = merge(model_mem[idx], wd, mask);
         if (mask == 4'hF) model_known[idx] = 1'b1;
      end
   endtask

   // Drive one request with resp_ready=1; return response and latency (accept edge counts as 1)
   task automatic txn(input logic [2:0] op, input logic [15:0] tid, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] wd,
                      output logic [50:0] r, output int lat, output bit ok);
      int n;
      ok = 1'b1;
      r = '0;
      lat = 0;
      resp_ready = 1'b1;
      req = {op, tid, addr, mask, wd};
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
      @(posedge clk); #1;
      model_apply(op, addr, mask, wd);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < TMO) begin @(posedge clk); #1; lat++; end
      if (!resp_valid) begin ok = 1'b0; return; end
      r = resp;
      @(posedge clk); #1;
   endtask

   // ---- tests ----
   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp !== 51'h0) begin
            n_fail++;
            $display("FAIL reset_hold: ready=%b resp_valid=%b resp=%h, required 0/0/0", req_ready, resp_valid, resp);
         end
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b resp_valid=%b, required 0/0", req_ready, resp_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp !== 51'h0) begin
         n_fail++;
         $display("FAIL reset_after: ready=%b resp_valid=%b resp=%h, required 1/0/0", req_ready, resp_valid, resp);
      end
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      logic [50:0] r; int lat; bit ok;
      txn(3'd1, 16'h0012, 32'h10, 4'hF, 32'hDEADBEEF, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd1, 16'h0012, 32'h0} || lat !== LATENCY + 1) begin
         n_fail++;
         $display("FAIL write_full: ok=%0d resp=%h lat=%0d, required resp=%h lat=%0d", ok, r, lat,
                  {3'd1, 16'h0012, 32'h0}, LATENCY + 1);
      end
      txn(3'd0, 16'h0013, 32'h10, 4'h0, 32'h0, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd0, 16'h0013, model_mem[4]} || lat !== LATENCY + 1) begin
         n_fail++;
         $display("FAIL read_full: ok=%0d resp=%h lat=%0d, required resp=%h lat=%0d", ok, r, lat,
                  {3'd0, 16'h0013, model_mem[4]}, LATENCY + 1);
      end
      $display("test_write_read done: rdata=%h", r[31:0]);
   endtask

   task automatic test_byte_mask();
      logic [50:0] r; int lat; bit ok;
      txn(3'd1, 16'h0020, 32'h10, 4'b0101, 32'h11223344, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd1, 16'h0020, 32'h0}) begin
         n_fail++;
         $display("FAIL mask_write: ok=%0d resp=%h, required %h", ok, r, {3'd1, 16'h0020, 32'h0});
      end
      txn(3'd0, 16'h0021, 32'h10, 4'h0, 32'h0, r, lat, ok);
      n_checks++;
      if (!ok || r[31:0] !== model_mem[4] || model_mem[4] !== 32'hDE22BE44) begin
         n_fail++;
         $display("FAIL mask_read: ok=%0d rdata=%h, required %h", ok, r[31:0], 32'hDE22BE44);
      end
      $display("test_byte_mask done: rdata=%h", r[31:0]);
   endtask

   task automatic test_out_of_range();
      logic [50:0] r; int lat; bit ok;
      txn(3'd1, 16'h0030, 32'h0, 4'hF, 32'hA5A5_0F0F, r, lat, ok);
      txn(3'd0, 16'h0031, 32'h1000, 4'hF, 32'h0, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd7, 16'h0031, 32'h0}) begin
         n_fail++;
         $display("FAIL oor_read: ok=%0d resp=%h, required %h", ok, r, {3'd7, 16'h0031, 32'h0});
      end
      txn(3'd5, 16'h0032, 32'h0, 4'hF, 32'h1234_5678, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd7, 16'h0032, 32'h0}) begin
         n_fail++;
         $display("FAIL bad_op: ok=%0d resp=%h, required %h", ok, r, {3'd7, 16'h0032, 32'h0});
      end
      txn(3'd0, 16'h0033, 32'h0, 4'h0, 32'h0, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd0, 16'h0033, model_mem[0]}) begin
         n_fail++;
         $display("FAIL bad_op_untouched: ok=%0d resp=%h, required %h", ok, r, {3'd0, 16'h0033, model_mem[0]});
      end
      $display("test_out_of_range done");
   endtask

   task automatic test_backpressure();
      logic [50:0] held, r; int n;
      resp_ready = 1'b0;
      req = {3'd0, 16'h0040, 32'h10, 4'hF, 32'h0};
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < TMO) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req = {3'd0, 16'h0041, 32'h0, 4'hF, 32'h0};
      n = 0;
      while (!resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
      held = resp;
      n_checks++;
      if (held !== {3'd0, 16'h0040, model_mem[4]}) begin
         n_fail++;
         $display("FAIL bp_first_resp: resp=%h, required %h", held, {3'd0, 16'h0040, model_mem[4]});
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid !== 1'b1 || resp !== held || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b resp=%h ready=%b, required 1/%h/0", i, resp_valid, resp, req_ready, held);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b ready=%b, required 0/1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_second_accept: ready=%b, required 0", req_ready);
      end
      n = 0;
      while (!resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
      r = resp;
      n_checks++;
      if (r !== {3'd0, 16'h0041, model_mem[0]}) begin
         n_fail++;
         $display("FAIL bp_second_resp: resp=%h, required %h", r, {3'd0, 16'h0041, model_mem[0]});
      end
      @(posedge clk); #1;
      $display("test_backpressure done");
   endtask

   task automatic test_reset_mid();
      logic [50:0] r; int lat; bit ok; bit seen;
      req = {3'd1, 16'h0050, 32'h40, 4'hF, 32'hCAFE_F00D};
      req_valid = 1'b1;
      @(posedge clk); #1;       // ready is 1 here after previous handshake: accepted
      model_apply(3'd1, 32'h40, 4'hF, 32'hCAFE_F00D);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      seen = resp_valid;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen |= resp_valid;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_resp: resp_valid seen=%b, required 0", seen);
      end
      txn(3'd0, 16'h0051, 32'h40, 4'h0, 32'h0, r, lat, ok);
      n_checks++;
      if (!ok || r !== {3'd0, 16'h0051, 32'hCAFE_F00D}) begin
         n_fail++;
         $display("FAIL rst_mid_data: ok=%0d resp=%h, required %h", ok, r, {3'd0, 16'h0051, 32'hCAFE_F00D});
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_back_to_back();
      int base;
      resp_ready = 1'b1;
      req = {3'd0, 16'h0060, 32'h10, 4'hF, 32'h0};
      base = accept_cyc.size();
      req_valid = 1'b1;
      repeat (5 * (LATENCY + 2) + 2) @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (LATENCY + 4) @(posedge clk);
      #1;
      n_checks++;
      if (accept_cyc.size() - base < 4) begin
         n_fail++;
         $display("FAIL b2b_count: accepts=%0d, required >=4", accept_cyc.size() - base);
      end else begin
         for (int i = base + 1; i < base + 4; i++) begin
            n_checks++;
            if (accept_cyc[i] - accept_cyc[i-1] !== LATENCY + 2) begin
               n_fail++;
               $display("FAIL b2b_period[%0d]: period=%0d, required %0d", i - base,
                        accept_cyc[i] - accept_cyc[i-1], LATENCY + 2);
            end
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_random();
      logic [50:0] r, e; int lat; bit ok;
      logic [2:0] op; logic [15:0] tid; logic [31:0] addr, wd; logic [3:0] m; int idx;
      // Seed a small pool of words with known contents
      for (int w = 64; w < 72; w++) begin
         txn(3'd1, 16'(w), 32'(w * 4), 4'hF, $urandom, r, lat, ok);
      end
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 5))
            0, 1:    op = 3'd0;
            2, 3:    op = 3'd1;
            4:       op = 3'($urandom_range(2, 7));
            default: op = 3'd0;
         endcase
         if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
         else addr = 32'($urandom_range(64, 71) * 4 + $urandom_range(0, 3));
         tid = 16'($urandom);
         m   = 4'($urandom);
         wd  = $urandom;
         idx = int'(addr / 4);
         if (exp_op(op, addr) == 3'd0) e = {3'd0, tid, model_mem[idx]};
         else e = {exp_op(op, addr), tid, 32'h0};
         txn(op, tid, addr, m, wd, r, lat, ok);
         n_checks++;
         if (!ok || r !== e || lat !== LATENCY + 1) begin
            n_fail++;
            $display("FAIL rand[%0d]: op=%0d addr=%h resp=%h lat=%0d, required resp=%h lat=%0d",
                     t, op, addr, r, lat, e, LATENCY + 1);
         end else begin
            $display("rand[%0d] op=%0d addr=%h mask=%h resp=%h", t, op, addr, m, r);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin model_mem[i] = 32'h0; model_known[i] = 1'b0; end
      test_reset();
      test_write_read();
      test_byte_mask();
      test_out_of_range();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
